// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded WISC instruction fields into 16-bit words and
// writes them to instruction memory at consecutive word addresses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        field tuple handshake
//   in_op/rs/rt/rd/func/imm  decoded instruction fields
//   restart                  leaves DONE, rewinds address and count
//   mem_we/addr/wdata/ready  instruction memory write port
//   done                     HALT word has been written
//   err                      one-cycle pulse after a rejected opcode
//   count                    words written since reset/restart
//
// Optional feature: define ENC_ILLEGAL_CHECK_EN to reject SIIC/RTI
// (accepted but not written, err pulses); otherwise they encode as format None.
module inst_encoder #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [1:0]        in_func,
  input  logic [10:0]       in_imm,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0][15:0]  buf_q;
  logic              wp_q, rp_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, count_q, count_d;
  logic [15:0]       enc;
  logic              accept, push, pop, restart_go, ill;
  always_comb begin
    enc = {in_op, in_rs, in_rd, in_imm[4:0]};
    casez (in_op)
      5'b000??:                              enc = {in_op, 11'b0};
      5'b001?0:                              enc = {in_op, in_imm};
      5'b001?1, 5'b011??, 5'b10010, 5'b11000: enc = {in_op, in_rs, in_imm[7:0]};
      5'b11001, 5'b1101?, 5'b111??:          enc = {in_op, in_rs, in_rt, in_rd, in_func};
      default: ;
    endcase
  end
`ifdef ENC_ILLEGAL_CHECK_EN
  logic err_q;
  assign ill = in_op[4:1] == 4'b0001;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else     err_q <= accept & ill;
  assign err = err_q;
`else
  assign ill = 1'b0;
  assign err = 1'b0;
`endif
  assign mem_we     = cnt_q != 2'd0;
  assign pop        = mem_we & mem_ready;
  // a same-cycle pop frees a slot, so a full FIFO can still accept
  assign in_ready   = state_q == RUN && (cnt_q != 2'd2 || pop);
  assign accept     = in_valid & in_ready;
  assign push       = accept & ~ill;
  assign restart_go = state_q == DONE && restart;
  assign mem_wdata  = buf_q[rp_q];
  assign mem_addr   = addr_q;
  assign count      = count_q;
  assign done       = state_q == DONE;
  always_comb begin
    // HALT is always the last word in the FIFO, so the pop that empties it is the HALT pop
    state_d = restart_go                                ? RUN   :
              (state_q == RUN && accept && in_op == '0)   ? DRAIN :
              (state_q == DRAIN && pop && cnt_q == 2'd1)  ? DONE  : state_q;
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
    addr_d  = restart_go ? START_ADDR : pop ? addr_q + ADDR_W'(2) : addr_q;
    count_d = restart_go ? '0 : pop ? count_q + ADDR_W'(1) : count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      buf_q   <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      addr_q  <= START_ADDR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) buf_q[wp_q] <= enc;
      wp_q    <= wp_q ^ push;
      rp_q    <= rp_q ^ pop;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed table-driven and sequence checks for inst_encoder.
module tb_inst_encoder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, restart = 1'b0, mem_we, mem_ready = 1'b1, done, err;
  logic [4:0]  in_op = '0;
  logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [1:0]  in_func = '0;
  logic [10:0] in_imm = '0;
  logic [15:0] mem_addr, mem_wdata, count;
  int tests = 0, fails = 0;

  inst_encoder #(.ADDR_W(16), .START_ADDR(16'd0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_func(in_func), .in_imm(in_imm), .restart(restart),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rs, rt, rd;
    logic [1:0]  func;
    logic [10:0] imm;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [1:0] func, input logic [10:0] imm);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_func = func; in_imm = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; restart = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 11'h01F, 16'h415F};
    vecs[1] = '{5'b11011, 3'd3, 3'd4, 3'd5, 2'd0, 11'h000, 16'hDB94};
    vecs[2] = '{5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FF, 16'h27FF};
    vecs[3] = '{5'b11000, 3'd6, 3'd0, 3'd0, 2'd0, 11'h7A5, 16'hC6A5};
    vecs[4] = '{5'b10011, 3'd7, 3'd0, 3'd1, 2'd0, 11'h7EA, 16'h9F2A};
    vecs[5] = '{5'b00001, 3'd7, 3'd7, 3'd7, 2'd3, 11'h7FF, 16'h0800};
    vecs[6] = '{5'b11101, 3'd1, 3'd2, 3'd3, 2'd3, 11'h000, 16'hE94F};
    vecs[7] = '{5'b00110, 3'd0, 3'd0, 3'd0, 2'd0, 11'h123, 16'h3123};
    vecs[8] = '{5'b00101, 3'd2, 3'd0, 3'd0, 2'd0, 11'h0FF, 16'h2AFF};
    vecs[9] = '{5'b10100, 3'd0, 3'd0, 3'd7, 2'd0, 11'h011, 16'hA0F1};

    do_reset();
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].func, vecs[i].imm);
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_we", i), 32'(mem_we), 1);
      check($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].exp));
      check($sformatf("vec%0d_addr", i), 32'(mem_addr), 2 * i);
    end
    @(negedge clk);
    check("vec_count", 32'(count), 10);
    check("vec_addr_end", 32'(mem_addr), 20);
    check("vec_idle_we", 32'(mem_we), 0);

    do_reset();
    @(negedge clk); drive(5'b11011, 3'd3, 3'd4, 3'd5, 2'd0, 11'h0);
    @(negedge clk); drive(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FF);
    check("b2b_ready", 32'(in_ready), 1);
    check("b2b_w0", 32'(mem_wdata), 32'hDB94);
    check("b2b_a0", 32'(mem_addr), 0);
    @(negedge clk); in_valid = 1'b0;
    check("b2b_we1", 32'(mem_we), 1);
    check("b2b_w1", 32'(mem_wdata), 32'h27FF);
    check("b2b_a1", 32'(mem_addr), 2);
    @(negedge clk);
    check("b2b_we_off", 32'(mem_we), 0);
    check("b2b_count", 32'(count), 2);

    do_reset();
    mem_ready = 1'b0;
    @(negedge clk); drive(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 11'h01F);
    check("bp_ready0", 32'(in_ready), 1);
    @(negedge clk); drive(5'b11011, 3'd3, 3'd4, 3'd5, 2'd0, 11'h0);
    check("bp_ready1", 32'(in_ready), 1);
    @(negedge clk); drive(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FF);
    check("bp_full", 32'(in_ready), 0);
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_ready", 32'(in_ready), 0);
      check("bp_hold_we", 32'(mem_we), 1);
      check("bp_hold_wdata", 32'(mem_wdata), 32'h415F);
      check("bp_hold_addr", 32'(mem_addr), 0);
    end
    mem_ready = 1'b1;
    #1 check("bp_pop_ready", 32'(in_ready), 1);
    @(negedge clk); in_valid = 1'b0;
    check("bp_w1", 32'(mem_wdata), 32'hDB94);
    check("bp_a1", 32'(mem_addr), 2);
    @(negedge clk);
    check("bp_w2", 32'(mem_wdata), 32'h27FF);
    check("bp_a2", 32'(mem_addr), 4);
    @(negedge clk);
    check("bp_we_off", 32'(mem_we), 0);
    check("bp_count", 32'(count), 3);

    do_reset();
    @(negedge clk); drive(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 11'h01F);
    @(negedge clk); drive(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FF);
    check("halt_w0", 32'(mem_wdata), 32'h415F);
    @(negedge clk); drive(5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 11'h0);
    check("halt_w1", 32'(mem_wdata), 32'h27FF);
    check("halt_a1", 32'(mem_addr), 2);
    @(negedge clk); drive(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 11'h01F);
    check("halt_drain_ready", 32'(in_ready), 0);
    check("halt_we", 32'(mem_we), 1);
    check("halt_word", 32'(mem_wdata), 0);
    check("halt_addr", 32'(mem_addr), 4);
    check("halt_done_early", 32'(done), 0);
    @(negedge clk);
    check("halt_done", 32'(done), 1);
    check("halt_done_we", 32'(mem_we), 0);
    check("halt_done_ready", 32'(in_ready), 0);
    check("halt_count", 32'(count), 3);
    @(negedge clk);
    check("halt_stay_done", 32'(done), 1);
    check("halt_stay_we", 32'(mem_we), 0);
    in_valid = 1'b0; restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("rs_done", 32'(done), 0);
    check("rs_ready", 32'(in_ready), 1);
    check("rs_addr", 32'(mem_addr), 0);
    check("rs_count", 32'(count), 0);
    drive(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FF);
    @(negedge clk); in_valid = 1'b0;
    check("rs_wdata", 32'(mem_wdata), 32'h27FF);
    check("rs_waddr", 32'(mem_addr), 0);
    @(negedge clk);
    check("rs_count1", 32'(count), 1);
    restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    check("rs_ignored_addr", 32'(mem_addr), 2);
    check("rs_ignored_count", 32'(count), 1);

    do_reset();
    @(negedge clk); drive(5'b00010, 3'd5, 3'd0, 3'd0, 2'd0, 11'h7FF);
    check("ill_ready", 32'(in_ready), 1);
    @(negedge clk); in_valid = 1'b0;
`ifdef ENC_ILLEGAL_CHECK_EN
    check("ill_no_we", 32'(mem_we), 0);
    check("ill_err", 32'(err), 1);
    @(negedge clk);
    check("ill_err_pulse", 32'(err), 0);
    check("ill_count", 32'(count), 0);
    check("ill_addr", 32'(mem_addr), 0);
`else
    check("ill_we", 32'(mem_we), 1);
    check("ill_wdata", 32'(mem_wdata), 32'h1000);
    check("ill_addr", 32'(mem_addr), 0);
    check("ill_err", 32'(err), 0);
    @(negedge clk);
    check("ill_count", 32'(count), 1);
`endif

    do_reset();
    @(negedge clk); drive(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 11'h01F);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); mem_ready = 1'b0; drive(5'b11011, 3'd3, 3'd4, 3'd5, 2'd0, 11'h0);
    @(negedge clk); drive(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 11'h7FF);
    @(negedge clk); in_valid = 1'b0;
    check("mr_full", 32'(in_ready), 0);
    check("mr_we", 32'(mem_we), 1);
    check("mr_addr", 32'(mem_addr), 2);
    rst = 1'b1;
    #1;
    check("mr_async_we", 32'(mem_we), 0);
    check("mr_async_addr", 32'(mem_addr), 0);
    check("mr_async_count", 32'(count), 0);
    @(negedge clk); rst = 1'b0;
    check("mr_ready", 32'(in_ready), 1);
    check("mr_we_off", 32'(mem_we), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
